tc_pl_cap_gain_seq: RTL and testbench

//  Sequences one capture run over up to four gain steps using the frozen PL capture config (gain cycles, Lddel, DACs, lmh, relay).
//  Per step: drive front-end settings, pulse DAC load, wait settle time, open capture gate for cycle count, then advance.

---
 rtl/tc_pl_cap_pkg.sv | 15 +
 rtl/tc_pl_cap_dwell_cnt.sv | 20 ++
 rtl/tc_pl_cap_gain_seq.sv | 162 ++++++++++++++++
 tb/tb_tc_pl_cap_gain_seq.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/tc_pl_cap_pkg.sv
// tc_pl_cap_pkg: shared types and default widths for the PL capture gain sequencer.
package tc_pl_cap_pkg;
  localparam int PL_NGAIN  = 4;
  localparam int PL_GI_W   = 2;
  localparam int PL_CYC_W  = 18;
  localparam int PL_DEL_W  = 32;
  localparam int PL_DAC_W  = 32;
  localparam int PL_LMH_W  = 6;
  localparam int PL_RLY_W  = 4;
  localparam int PL_TIME_W = 32;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETTLE, S_RUN, S_NEXT, S_DONE} state_t;
  function automatic int max_w(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/tc_pl_cap_dwell_cnt.sv
// tc_pl_cap_dwell_cnt: loadable unsigned down-counter shared by the settle and capture phases.
module tc_pl_cap_dwell_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  input  logic         i_en,
  output logic         o_zero,
  output logic         o_one
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else if (i_load) r_cnt <= i_val;
    else if (i_en && r_cnt != '0) r_cnt <= r_cnt - W'(1);
  assign o_zero = (r_cnt == '0);
  assign o_one  = (r_cnt == W'(1));
endmodule

// File: rtl/tc_pl_cap_gain_seq.sv
// tc_pl_cap_gain_seq: steps one capture run over up to NGAIN gain settings (load, settle, gate, advance).
// Optional run-time stamping into cap_time is enabled by defining CAP_SEQ_TIMESTAMP_EN.
module tc_pl_cap_gain_seq
  import tc_pl_cap_pkg::*;
#(
  parameter int NGAIN  = PL_NGAIN,
  parameter int GI_W   = PL_GI_W,
  parameter int CYC_W  = PL_CYC_W,
  parameter int DEL_W  = PL_DEL_W,
  parameter int DAC_W  = PL_DAC_W,
  parameter int LMH_W  = PL_LMH_W,
  parameter int RLY_W  = PL_RLY_W,
  parameter int TIME_W = PL_TIME_W
) (
  input  logic                   clk125,
  input  logic                   rst_n,
  input  logic                   cap_start,
  input  logic                   cap_abort,
  input  logic                   cap_irq_en,
  input  logic [2:0]             cap_gain_number,
  input  logic [NGAIN*CYC_W-1:0] cyc_flat,
  input  logic [NGAIN*DEL_W-1:0] del_flat,
  input  logic [NGAIN*DAC_W-1:0] daca_flat,
  input  logic [NGAIN*DAC_W-1:0] dacb_flat,
  input  logic [NGAIN*LMH_W-1:0] lmh_flat,
  input  logic [NGAIN*RLY_W-1:0] rly_flat,
  output logic                   cap_cing,
  output logic [GI_W-1:0]        gain_sel,
  output logic [DAC_W-1:0]       dac_a,
  output logic [DAC_W-1:0]       dac_b,
  output logic                   dac_ld,
  output logic [LMH_W-1:0]       lmh,
  output logic [RLY_W-1:0]       relay,
  output logic                   cap_gate,
  output logic                   cap_done,
  output logic                   cap_irq,
  output logic [TIME_W-1:0]      cap_time
);
  localparam int CW = max_w(CYC_W, DEL_W);
  state_t            r_state;
  logic [GI_W-1:0]   r_gsel;
  logic [DAC_W-1:0]  r_dac_a, r_dac_b;
  logic [LMH_W-1:0]  r_lmh;
  logic [RLY_W-1:0]  r_rly;
  logic              r_cing, r_gate, r_dac_ld, r_done, r_irq;
  logic [GI_W-1:0]   w_last, w_ld_idx;
  logic              w_zero, w_one, w_start, w_next_ld, w_ld_del, w_go_run, w_run_end, w_to_done;
  logic [CW-1:0]     w_cnt_val;
  logic [CYC_W-1:0]  w_cyc;
  assign w_last    = (cap_gain_number > 3'(NGAIN - 1)) ? GI_W'(NGAIN - 1) : cap_gain_number[GI_W-1:0];
  assign w_ld_idx  = (r_state == S_NEXT) ? r_gsel + GI_W'(1) : '0;
  assign w_cyc     = cyc_flat[int'(r_gsel)*CYC_W +: CYC_W];
  assign w_start   = (r_state == S_IDLE) && cap_start && !cap_abort;
  assign w_next_ld = (r_state == S_NEXT) && !cap_abort && (r_gsel != w_last);
  assign w_to_done = (r_state == S_NEXT) && !cap_abort && (r_gsel == w_last);
  assign w_ld_del  = w_start || w_next_ld;
  // A remaining count of one means this is the final settle/gate cycle.
  assign w_go_run  = !cap_abort && (((r_state == S_LOAD) && w_zero) ||
                                    ((r_state == S_SETTLE) && (w_zero || w_one)));
  assign w_run_end = (r_state == S_RUN) && (w_zero || w_one);
  assign w_cnt_val = w_ld_del ? CW'(del_flat[int'(w_ld_idx)*DEL_W +: DEL_W]) : CW'(w_cyc);
  tc_pl_cap_dwell_cnt #(.W(CW)) u_dwell (
    .clk    (clk125),
    .rst_n  (rst_n),
    .i_load (w_ld_del || w_go_run),
    .i_val  (w_cnt_val),
    .i_en   ((r_state == S_SETTLE) || (r_state == S_RUN)),
    .o_zero (w_zero),
    .o_one  (w_one)
  );
  always_ff @(posedge clk125 or negedge rst_n)
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_gsel   <= '0;
      r_dac_a  <= '0;
      r_dac_b  <= '0;
      r_lmh    <= '0;
      r_rly    <= '0;
      r_cing   <= 1'b0;
      r_gate   <= 1'b0;
      r_dac_ld <= 1'b0;
      r_done   <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_dac_ld <= 1'b0;
      r_done   <= 1'b0;
      r_irq    <= 1'b0;
      if (w_ld_del) begin
        r_dac_a  <= daca_flat[int'(w_ld_idx)*DAC_W +: DAC_W];
        r_dac_b  <= dacb_flat[int'(w_ld_idx)*DAC_W +: DAC_W];
        r_lmh    <= lmh_flat[int'(w_ld_idx)*LMH_W +: LMH_W];
        r_rly    <= rly_flat[int'(w_ld_idx)*RLY_W +: RLY_W];
        r_dac_ld <= 1'b1;
      end
      if (cap_abort && r_state != S_IDLE) begin
        r_state <= S_IDLE;
        r_gate  <= 1'b0;
        r_cing  <= 1'b0;
        r_gsel  <= '0;
      end else begin
        case (r_state)
          S_IDLE: if (w_start) begin
            r_state <= S_LOAD;
            r_cing  <= 1'b1;
            r_gsel  <= '0;
          end
          S_LOAD: begin
            r_state <= w_zero ? S_RUN : S_SETTLE;
            r_gate  <= w_zero && (w_cyc != '0);
          end
          S_SETTLE: if (w_go_run) begin
            r_state <= S_RUN;
            r_gate  <= (w_cyc != '0);
          end
          S_RUN: if (w_run_end) begin
            r_state <= S_NEXT;
            r_gate  <= 1'b0;
          end
          S_NEXT: if (w_to_done) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_irq   <= cap_irq_en;
            r_cing  <= 1'b0;
          end else begin
            r_state <= S_LOAD;
            r_gsel  <= w_ld_idx;
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_gsel  <= '0;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
`ifdef CAP_SEQ_TIMESTAMP_EN
  logic [TIME_W-1:0] r_ts, r_time, w_ts_inc;
  assign w_ts_inc = (&r_ts) ? r_ts : r_ts + TIME_W'(1);
  // The DONE edge still counts the final NEXT cycle, so latch the incremented value.
  always_ff @(posedge clk125 or negedge rst_n)
    if (!rst_n) begin
      r_ts   <= '0;
      r_time <= '0;
    end else begin
      r_ts <= w_start ? '0 : (r_cing ? w_ts_inc : r_ts);
      if (w_to_done) r_time <= w_ts_inc;
    end
  assign cap_time = r_time;
`else
  assign cap_time = '0;
`endif
  assign cap_cing = r_cing;
  assign gain_sel = r_gsel;
  assign dac_a    = r_dac_a;
  assign dac_b    = r_dac_b;
  assign dac_ld   = r_dac_ld;
  assign lmh      = r_lmh;
  assign relay    = r_rly;
  assign cap_gate = r_gate;
  assign cap_done = r_done;
  assign cap_irq  = r_irq;
endmodule

// File: tb/tb_tc_pl_cap_gain_seq.sv
// tb_tc_pl_cap_gain_seq: directed runs with a queue scoreboard checking gate windows and run completions.
module tb_tc_pl_cap_gain_seq;
  logic         clk125 = 1'b0, rst_n = 1'b0;
  logic         cap_start = 1'b0, cap_abort = 1'b0, cap_irq_en = 1'b0;
  logic [2:0]   cap_gain_number = '0;
  logic [71:0]  cyc_flat = '0;
  logic [127:0] del_flat = '0, daca_flat = '0, dacb_flat = '0;
  logic [23:0]  lmh_flat = '0;
  logic [15:0]  rly_flat = '0;
  logic         cap_cing, dac_ld, cap_gate, cap_done, cap_irq;
  logic [1:0]   gain_sel;
  logic [31:0]  dac_a, dac_b, cap_time;
  logic [5:0]   lmh;
  logic [3:0]   relay;
  typedef struct {bit is_done; int a; logic [31:0] b;} exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0, gw = 0, gs = 0;
`ifdef CAP_SEQ_TIMESTAMP_EN
  localparam bit TS = 1'b1;
`else
  localparam bit TS = 1'b0;
`endif
  tc_pl_cap_gain_seq dut (
    .clk125(clk125), .rst_n(rst_n), .cap_start(cap_start), .cap_abort(cap_abort),
    .cap_irq_en(cap_irq_en), .cap_gain_number(cap_gain_number), .cyc_flat(cyc_flat),
    .del_flat(del_flat), .daca_flat(daca_flat), .dacb_flat(dacb_flat), .lmh_flat(lmh_flat),
    .rly_flat(rly_flat), .cap_cing(cap_cing), .gain_sel(gain_sel), .dac_a(dac_a), .dac_b(dac_b),
    .dac_ld(dac_ld), .lmh(lmh), .relay(relay), .cap_gate(cap_gate), .cap_done(cap_done),
    .cap_irq(cap_irq), .cap_time(cap_time)
  );
  always #4 clk125 = ~clk125;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  function automatic logic [31:0] ts(input int v);
    return TS ? 32'(v) : 32'd0;
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic push_gate(input int g, input int w);
    exp_t e;
    e.is_done = 1'b0; e.a = g; e.b = 32'(w);
    q.push_back(e);
  endtask
  task automatic push_done(input int irq, input int t);
    exp_t e;
    e.is_done = 1'b1; e.a = irq; e.b = ts(t);
    q.push_back(e);
  endtask
  task automatic pop_cmp(input bit d, input int a, input logic [31:0] b);
    exp_t e;
    if (q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL unexpected_%s: got a=%0d b=%0d expected no event", d ? "done" : "gate", a, b);
    end else begin
      e = q.pop_front();
      chk(d ? "done_kind" : "gate_kind", 64'(d), 64'(e.is_done));
      chk(d ? "done_irq" : "gate_gsel", 64'(a), 64'(e.a));
      chk(d ? "done_time" : "gate_width", 64'(b), 64'(e.b));
    end
  endtask
  always @(negedge clk125) begin
    if (!rst_n) gw = 0;
    else begin
      if (cap_gate) begin
        if (gw == 0) gs = int'(gain_sel);
        gw++;
      end else if (gw > 0) begin
        pop_cmp(1'b0, gs, 32'(gw));
        gw = 0;
      end
      if (cap_done) pop_cmp(1'b1, int'(cap_irq), cap_time);
    end
  end
  task automatic set_gain(input int i, input int c, input int d);
    cyc_flat[i*18 +: 18] = 18'(c);
    del_flat[i*32 +: 32] = 32'(d);
  endtask
  task automatic start_run();
    @(posedge clk125); #1 cap_start = 1'b1;
    @(posedge clk125); #1 cap_start = 1'b0;
  endtask
  task automatic wait_done(input string nm);
    int k;
    for (k = 0; k < 400; k++) begin
      @(negedge clk125);
      if (cap_done) break;
    end
    chk({nm, "_done_in_time"}, 64'(k < 400), 64'd1);
  endtask
  task automatic wait_gate(input string nm, input int g);
    int k;
    for (k = 0; k < 400; k++) begin
      @(negedge clk125);
      if (cap_gate && gain_sel == 2'(g)) break;
    end
    chk({nm, "_gate_in_time"}, 64'(k < 400), 64'd1);
  endtask
  task automatic chk_all_zero(input string nm);
    chk({nm, "_ctrl"}, {59'd0, cap_cing, dac_ld, cap_gate, cap_done, cap_irq}, 64'd0);
    chk({nm, "_sel"}, {gain_sel, lmh, relay}, 64'd0);
    chk({nm, "_dac"}, {dac_a, dac_b}, 64'd0);
    chk({nm, "_time"}, 64'(cap_time), 64'd0);
  endtask
  initial begin
    for (int i = 0; i < 4; i++) begin
      daca_flat[i*32 +: 32] = 32'hA000_0000 + 32'(i);
      dacb_flat[i*32 +: 32] = 32'hB000_0000 + 32'(i);
      lmh_flat[i*6 +: 6]    = 6'(i + 5);
      rly_flat[i*4 +: 4]    = 4'(i + 9);
    end
    repeat (2) @(negedge clk125);
    chk_all_zero("reset");
    @(posedge clk125); #1 rst_n = 1'b1;
    // 1: single step, exact cycle timing
    cap_irq_en = 1'b1; cap_gain_number = 3'd0;
    set_gain(0, 5, 3);
    push_gate(0, 5); push_done(1, 10);
    start_run();
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk125);
      chk($sformatf("t1_dac_ld_t%0d", k), 64'(dac_ld), 64'(k == 1));
      chk($sformatf("t1_gate_t%0d", k), 64'(cap_gate), 64'(k >= 5 && k <= 9));
      chk($sformatf("t1_cing_t%0d", k), 64'(cap_cing), 64'(k <= 10));
      chk($sformatf("t1_done_t%0d", k), 64'(cap_done), 64'(k == 11));
      if (k == 1) chk("t1_fe", {dac_a, dac_b, 16'(lmh), 16'(relay)}, {32'hA000_0000, 32'hB000_0000, 16'd5, 16'd9});
    end
    // 2: four steps, zero settle, irq disabled
    cap_irq_en = 1'b0; cap_gain_number = 3'd3;
    set_gain(0, 4, 0); set_gain(1, 3, 0); set_gain(2, 2, 0); set_gain(3, 1, 0);
    push_gate(0, 4); push_gate(1, 3); push_gate(2, 2); push_gate(3, 1); push_done(0, 18);
    start_run();
    wait_done("t2");
    chk("t2_hold_fe", {dac_a, 16'(lmh), 16'(relay)}, {32'hA000_0003, 16'd8, 16'd12});
    // 3: clamped step count, gain 1 with zero cycles
    cap_irq_en = 1'b1; cap_gain_number = 3'd7;
    set_gain(0, 2, 1); set_gain(1, 0, 0); set_gain(2, 1, 2); set_gain(3, 3, 0);
    push_gate(0, 2); push_gate(2, 1); push_gate(3, 3); push_done(1, 18);
    start_run();
    wait_done("t3");
    // 4: abort in RUN of gain 2, then restart
    cap_gain_number = 3'd3;
    set_gain(0, 2, 0); set_gain(1, 2, 0); set_gain(2, 6, 0); set_gain(3, 2, 0);
    push_gate(0, 2); push_gate(1, 2); push_gate(2, 2);
    start_run();
    wait_gate("t4", 2);
    @(posedge clk125); #1 cap_abort = 1'b1;
    @(posedge clk125); #1 cap_abort = 1'b0;
    @(negedge clk125);
    chk("t4_abort_ctrl", {60'd0, cap_gate, cap_cing, cap_done, cap_irq}, 64'd0);
    chk("t4_abort_gsel", 64'(gain_sel), 64'd0);
    chk("t4_abort_time", 64'(cap_time), 64'(ts(18)));
    repeat (6) @(negedge clk125);
    chk("t4_idle_cing", 64'(cap_cing), 64'd0);
    cap_gain_number = 3'd0; set_gain(0, 3, 0);
    push_gate(0, 3); push_done(1, 5);
    start_run();
    @(negedge clk125);
    chk("t4_restart", {30'd0, gain_sel, dac_ld, cap_cing, dac_a}, {32'd3, 32'hA000_0000});
    wait_done("t4r");
    // 5: start during RUN ignored, then async reset mid-run
    cap_gain_number = 3'd1; set_gain(0, 3, 0); set_gain(1, 3, 0);
    push_gate(0, 3); push_gate(1, 3); push_done(1, 10);
    start_run();
    wait_gate("t5", 0);
    @(posedge clk125); #1 cap_start = 1'b1;
    @(posedge clk125); #1 cap_start = 1'b0;
    wait_done("t5");
    repeat (20) @(negedge clk125);
    chk("t5_single_run", 64'(cap_cing), 64'd0);
    cap_gain_number = 3'd0; set_gain(0, 10, 0);
    start_run();
    wait_gate("t5r", 0);
    @(posedge clk125); #2 rst_n = 1'b0;
    #1 chk_all_zero("t5_async_rst");
    @(posedge clk125); #1 rst_n = 1'b1;
    repeat (4) @(negedge clk125);
    chk("q_empty", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
